adder_result_fifo: RTL and testbench

Downstream consumer of the adder stage. Captures each sum the adder produces when it flags the sum valid, and buffers it in a small first-word-fall-through FIFO for a ready/valid consumer. Keeps a saturating count of results dropped on overflow and a running accumulator of delivered results, giving the bench an end-to-end checksum of the adder path.

---
 rtl/adder_pkg.sv | 11 +
 rtl/adder_result_fifo.sv | 86 ++++++++
 tb/tb_adder_result_fifo.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared constants and types for the adder path and its result consumers.
package adder_pkg;

    localparam int ADD_DATA_W     = 5;
    localparam int ADD_FIFO_DEPTH = 4;
    localparam int ADD_ACC_W      = 16;

    typedef logic [ADD_DATA_W-1:0] sum_t;
    typedef logic [7:0]            drop_cnt_t;

endpackage

// File: rtl/adder_result_fifo.sv
// First-word-fall-through buffer for adder sums, with a saturating overflow
// drop counter and a running checksum of every sum handed to the consumer.
module adder_result_fifo
    import adder_pkg::*;
#(
    parameter  int DATA_W = ADD_DATA_W,
    parameter  int DEPTH  = ADD_FIFO_DEPTH,
    parameter  int ACC_W  = ADD_ACC_W,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_sum,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output drop_cnt_t         drop_cnt,
    output logic [ACC_W-1:0]  acc
);

    localparam int PTR_W = $clog2(DEPTH);

    // Handshake: the head entry transfers on any rising edge where
    // out_valid and out_ready are both high; upstream has no backpressure,
    // so an in_valid sum that finds no room is counted and discarded.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              push;
    logic              pop;
    logic              drop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign out_valid = ~empty;
    assign out_sum   = empty ? '0 : mem[rd_ptr];

    assign pop  = out_valid & out_ready;
    assign push = in_valid & (~full | pop);
    assign drop = in_valid & full & ~pop;

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_sum;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            acc     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                acc    <= acc + ACC_W'(out_sum);
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_adder_result_fifo.sv
// Bench for adder_result_fifo: queue-based reference model checked every
// cycle, plus directed checks of reset, ordering, overflow and saturation.
module tb_adder_result_fifo;
    import adder_pkg::*;

    localparam int DATA_W = ADD_DATA_W;
    localparam int DEPTH  = ADD_FIFO_DEPTH;
    localparam int ACC_W  = ADD_ACC_W;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_sum;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_sum;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    drop_cnt_t         drop_cnt;
    logic [ACC_W-1:0]  acc;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [ACC_W-1:0]  mdl_acc;
    logic [7:0]        mdl_drop;
    bit                mdl_on = 1'b0;
    bit                mdl_pop;
    bit                mdl_push;
    logic [ACC_W-1:0]  stream_sum;

    adder_result_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .drop_cnt  (drop_cnt),
        .acc       (acc)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time budget expired, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // drivers: inputs change 1 time unit after the rising edge
    task automatic cycle(input logic iv, input logic [DATA_W-1:0] s, input logic ordy);
        in_valid  = iv;
        in_sum    = s;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0);
        rst = 1'b0;
    endtask

    // scoreboard: check state at the falling edge, then predict the next edge
    always @(negedge clk) begin
        if (mdl_on) begin
            check_eq("sb_valid", out_valid, exp_q.size() != 0);
            check_eq("sb_count", count, exp_q.size());
            check_eq("sb_full", full, exp_q.size() == DEPTH);
            check_eq("sb_empty", empty, exp_q.size() == 0);
            check_eq("sb_sum", out_sum, (exp_q.size() != 0) ? exp_q[0] : '0);
            check_eq("sb_acc", acc, mdl_acc);
            check_eq("sb_drop", drop_cnt, mdl_drop);
        end
        if (rst) begin
            exp_q.delete();
            mdl_acc  = '0;
            mdl_drop = '0;
            mdl_on   = 1'b1;
        end else if (mdl_on) begin
            mdl_pop  = (exp_q.size() != 0) && out_ready;
            mdl_push = in_valid && ((exp_q.size() < DEPTH) || mdl_pop);
            if (in_valid && !mdl_push && mdl_drop != 8'hFF) mdl_drop = mdl_drop + 8'd1;
            if (mdl_pop) begin
                mdl_acc = mdl_acc + ACC_W'(exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (mdl_push) exp_q.push_back(in_sum);
        end
    end

    initial begin
        logic [DATA_W-1:0] v;
        logic [DATA_W-1:0] ord_vals [3];
        logic [DATA_W-1:0] pp_vals [4];
        ord_vals = '{5'd3, 5'd9, 5'd31};
        pp_vals  = '{5'd2, 5'd3, 5'd4, 5'd8};

        // reset held two cycles with a live input
        rst = 1'b1;
        cycle(1'b1, 5'd7, 1'b0);
        cycle(1'b1, 5'd7, 1'b0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_sum", out_sum, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_drop", drop_cnt, 0);
        check_eq("rst_acc", acc, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);

        // order and one-cycle latency
        cycle(1'b1, 5'd3, 1'b0);
        check_eq("lat_valid", out_valid, 1);
        check_eq("lat_sum", out_sum, 3);
        cycle(1'b1, 5'd9, 1'b0);
        cycle(1'b1, 5'd31, 1'b0);
        check_eq("ord_count", count, 3);
        for (int i = 0; i < 3; i++) begin
            check_eq("ord_sum", out_sum, ord_vals[i]);
            cycle(1'b0, '0, 1'b1);
        end
        check_eq("ord_acc", acc, 43);
        check_eq("ord_empty", empty, 1);
        cycle(1'b0, '0, 1'b1);
        check_eq("ready_empty_count", count, 0);

        // overflow
        do_reset();
        for (int i = 1; i <= 6; i++) cycle(1'b1, DATA_W'(i), 1'b0);
        check_eq("ovf_full", full, 1);
        check_eq("ovf_count", count, 4);
        check_eq("ovf_drop", drop_cnt, 2);
        for (int i = 1; i <= 4; i++) begin
            check_eq("ovf_sum", out_sum, i);
            cycle(1'b0, '0, 1'b1);
        end
        check_eq("ovf_empty", empty, 1);
        check_eq("ovf_acc", acc, 10);

        // simultaneous push and pop at full
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b1, DATA_W'(i), 1'b0);
        cycle(1'b1, 5'd8, 1'b1);
        check_eq("pp_count", count, 4);
        check_eq("pp_drop", drop_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            check_eq("pp_sum", out_sum, pp_vals[i]);
            cycle(1'b0, '0, 1'b1);
        end
        check_eq("pp_acc", acc, 1 + 2 + 3 + 4 + 8);

        // streaming across pointer wrap, then drop-counter saturation
        do_reset();
        stream_sum = '0;
        for (int i = 0; i < 10; i++) begin
            v = DATA_W'($urandom_range(0, 31));
            stream_sum = stream_sum + ACC_W'(v);
            cycle(1'b1, v, 1'b1);
        end
        cycle(1'b0, '0, 1'b1);
        check_eq("wrap_acc", acc, stream_sum);
        check_eq("wrap_empty", empty, 1);
        for (int i = 0; i < 300; i++) cycle(1'b1, DATA_W'($urandom_range(0, 31)), 1'b0);
        check_eq("sat_drop", drop_cnt, 255);
        check_eq("sat_count", count, 4);
        check_eq("sat_full", full, 1);

        // reset in the middle of traffic
        do_reset();
        cycle(1'b1, 5'd5, 1'b0);
        cycle(1'b1, 5'd6, 1'b0);
        cycle(1'b1, 5'd7, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'd9, 1'b0);
        check_eq("mid_pre_acc", acc, 5);
        check_eq("mid_pre_drop", drop_cnt, 1);
        rst = 1'b1;
        cycle(1'b1, 5'd12, 1'b1);
        rst      = 1'b0;
        in_valid = 1'b0;
        check_eq("mid_count", count, 0);
        check_eq("mid_acc", acc, 0);
        check_eq("mid_valid", out_valid, 0);
        check_eq("mid_drop", drop_cnt, 0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
